// File: rtl/uart_tx.sv
// Buffered UART transmitter: a small FIFO feeds a frame serialiser that sends
// start, data LSB first, optional check bit, then END_WIDTH*BL clocks of stop.
module uart_tx #(
  parameter int    CLK_FRAC   = 50,
  parameter int    BAUD       = 19200,
  parameter int    DATA_WIDTH = 8,
  parameter string CHECK_BIT  = "none",
  parameter int    END_WIDTH  = 1,
  parameter int    FIFO_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] i_user_tx_data,
  input  logic                  i_user_tx_valid,
  output logic                  o_user_tx_ready,
  output logic                  o_tx_busy,
  output logic                  uart_txd
);

  localparam int BL       = CLK_FRAC * 100000 / BAUD;
  localparam int STOP_LEN = END_WIDTH * BL;
  localparam int CNT_W    = (STOP_LEN > 1) ? $clog2(STOP_LEN) : 1;
  localparam int BIT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int AW       = $clog2(FIFO_DEPTH);

  localparam bit HAS_CHECK = (CHECK_BIT != "none");
  localparam bit IS_ODD    = (CHECK_BIT == "odd");
  localparam bit IS_MASK   = (CHECK_BIT == "mask");
  localparam bit IS_SPACE  = (CHECK_BIT == "space");

  localparam logic [CNT_W-1:0] BIT_LOAD   = CNT_W'(BL - 1);
  localparam logic [CNT_W-1:0] STOP_LOAD  = CNT_W'(STOP_LEN - 1);
  localparam logic [BIT_W-1:0] LAST_BIT   = BIT_W'(DATA_WIDTH - 1);
  localparam logic [AW:0]      FULL_COUNT = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, CHECK, STOP} state_t;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [AW:0]           count_q, count_d;
  logic                  ready_q, busy_q;

  state_t                state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [BIT_W-1:0]      bit_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic                  check_q;
  logic                  txd_q;

  logic                  push, pop, fifo_empty, seg_done, stop_done, fsm_idle_d;
  logic [DATA_WIDTH-1:0] pop_data, shift_nx;
  logic                  pop_check;

  assign o_user_tx_ready = ready_q;
  assign o_tx_busy       = busy_q;
  assign uart_txd        = txd_q;

  // A full FIFO refuses writes even when a pop happens on the same edge.
  assign push       = i_user_tx_valid & ready_q;
  assign fifo_empty = (count_q == '0);
  assign seg_done   = (cnt_q == '0);
  assign stop_done  = (state_q == STOP) && seg_done;
  assign pop        = !fifo_empty && ((state_q == IDLE) || stop_done);
  assign fsm_idle_d = ((state_q == IDLE) || stop_done) && !pop;

  assign pop_data  = mem[rd_ptr_q];
  assign pop_check = IS_MASK ? 1'b1 : IS_SPACE ? 1'b0 : ((^pop_data) ^ IS_ODD);
  assign shift_nx  = shift_q >> 1;

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + (AW + 1)'(1);
    end else if (pop && !push) begin
      count_d = count_q - (AW + 1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= i_user_tx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      ready_q <= (count_d != FULL_COUNT);
      busy_q  <= !fsm_idle_d || (count_d != '0);
    end
  end

  // Serialiser: cnt_q counts down the current line segment; a zero count
  // marks the last clock of that segment.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      check_q <= 1'b0;
      txd_q   <= 1'b1;
    end else begin
      if (!seg_done) cnt_q <= cnt_q - CNT_W'(1);
      unique case (state_q)
        IDLE: begin
          if (pop) begin
            state_q <= START;
            cnt_q   <= BIT_LOAD;
            shift_q <= pop_data;
            check_q <= pop_check;
            txd_q   <= 1'b0;
          end
        end
        START: begin
          if (seg_done) begin
            state_q <= DATA;
            cnt_q   <= BIT_LOAD;
            bit_q   <= '0;
            txd_q   <= shift_q[0];
          end
        end
        DATA: begin
          if (seg_done) begin
            if (bit_q != LAST_BIT) begin
              bit_q   <= bit_q + BIT_W'(1);
              shift_q <= shift_nx;
              txd_q   <= shift_nx[0];
              cnt_q   <= BIT_LOAD;
            end else if (HAS_CHECK) begin
              state_q <= CHECK;
              txd_q   <= check_q;
              cnt_q   <= BIT_LOAD;
            end else begin
              state_q <= STOP;
              txd_q   <= 1'b1;
              cnt_q   <= STOP_LOAD;
            end
          end
        end
        CHECK: begin
          if (seg_done) begin
            state_q <= STOP;
            txd_q   <= 1'b1;
            cnt_q   <= STOP_LOAD;
          end
        end
        STOP: begin
          if (seg_done) begin
            if (pop) begin
              // Next start bit follows the last stop clock with no gap.
              state_q <= START;
              cnt_q   <= BIT_LOAD;
              shift_q <= pop_data;
              check_q <= pop_check;
              txd_q   <= 1'b0;
            end else begin
              state_q <= IDLE;
              txd_q   <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          txd_q   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: five instances (even/odd/mask/space/none) share one stimulus
// stream and are each compared every clock against a frame-timeline model.
module tb_uart_tx;

  localparam int BL = 10;
  localparam int NI = 5;
  localparam int EW    [NI] = '{1, 1, 1, 1, 2};
  localparam int DEPTH [NI] = '{4, 4, 4, 4, 16};

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          valid = 1'b0;
  logic [7:0]    data = 8'h00;
  logic [NI-1:0] txd, ready, busy;
  bit            chk_en = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  uart_tx #(.CLK_FRAC(50), .BAUD(500000), .DATA_WIDTH(8), .CHECK_BIT("even"),
            .END_WIDTH(1), .FIFO_DEPTH(4)) u_dut_even (
    .clk(clk), .rst(rst), .i_user_tx_data(data), .i_user_tx_valid(valid),
    .o_user_tx_ready(ready[0]), .o_tx_busy(busy[0]), .uart_txd(txd[0]));
  uart_tx #(.CLK_FRAC(50), .BAUD(500000), .DATA_WIDTH(8), .CHECK_BIT("odd"),
            .END_WIDTH(1), .FIFO_DEPTH(4)) u_dut_odd (
    .clk(clk), .rst(rst), .i_user_tx_data(data), .i_user_tx_valid(valid),
    .o_user_tx_ready(ready[1]), .o_tx_busy(busy[1]), .uart_txd(txd[1]));
  uart_tx #(.CLK_FRAC(50), .BAUD(500000), .DATA_WIDTH(8), .CHECK_BIT("mask"),
            .END_WIDTH(1), .FIFO_DEPTH(4)) u_dut_mask (
    .clk(clk), .rst(rst), .i_user_tx_data(data), .i_user_tx_valid(valid),
    .o_user_tx_ready(ready[2]), .o_tx_busy(busy[2]), .uart_txd(txd[2]));
  uart_tx #(.CLK_FRAC(50), .BAUD(500000), .DATA_WIDTH(8), .CHECK_BIT("space"),
            .END_WIDTH(1), .FIFO_DEPTH(4)) u_dut_space (
    .clk(clk), .rst(rst), .i_user_tx_data(data), .i_user_tx_valid(valid),
    .o_user_tx_ready(ready[3]), .o_tx_busy(busy[3]), .uart_txd(txd[3]));
  uart_tx #(.CLK_FRAC(50), .BAUD(500000), .DATA_WIDTH(8), .CHECK_BIT("none"),
            .END_WIDTH(2), .FIFO_DEPTH(16)) u_dut_none (
    .clk(clk), .rst(rst), .i_user_tx_data(data), .i_user_tx_valid(valid),
    .o_user_tx_ready(ready[4]), .o_tx_busy(busy[4]), .uart_txd(txd[4]));

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Model: a queue of pending words plus the current frame as a list of line
  // levels, each held BL clocks; t is the clock index inside the frame.
  generate
    for (genvar gi = 0; gi < NI; gi++) begin : g_m
      logic [7:0]  q[$];
      logic [15:0] fr = '1;
      logic [7:0]  w;
      int          fl = 0;
      int          t = 0;
      int          nb = 0;
      bit          active = 1'b0;
      bit          ready_m = 1'b1;
      bit          busy_m = 1'b0;
      bit          push, pop, par, chk, exp_txd;

      always @(posedge clk) begin
        if (rst) begin
          q.delete();
          active  = 1'b0;
          t       = 0;
          ready_m = 1'b1;
          busy_m  = 1'b0;
        end else begin
          push = valid && ready_m;
          pop  = (q.size() != 0) && (!active || t == fl - 1);
          if (pop) begin
            w   = q.pop_front();
            par = 1'($countones(w) & 1);
            chk = (gi == 0) ? par : (gi == 1) ? ~par : (gi == 2);
            fr  = '1;
            fr[0] = 1'b0;
            for (int i = 0; i < 8; i++) fr[1 + i] = w[i];
            nb = 9;
            if (gi != 4) begin
              fr[9] = chk;
              nb = 10;
            end
            fl     = (nb + EW[gi]) * BL;
            t      = 0;
            active = 1'b1;
          end else if (active && t == fl - 1) begin
            active = 1'b0;
          end else if (active) begin
            t++;
          end
          if (push) q.push_back(data);
          ready_m = (q.size() != DEPTH[gi]);
          busy_m  = active || (q.size() != 0);
        end
      end

      always @(negedge clk) begin
        if (chk_en) begin
          exp_txd = active ? fr[t / BL] : 1'b1;
          check_eq($sformatf("txd[%0d]", gi),   32'(txd[gi]),   32'(exp_txd));
          check_eq($sformatf("ready[%0d]", gi), 32'(ready[gi]), 32'(ready_m));
          check_eq($sformatf("busy[%0d]", gi),  32'(busy[gi]),  32'(busy_m));
        end
      end
    end
  endgenerate

  // Hold valid with word w until the even instance (FIFO depth 4) takes it.
  task automatic send(input logic [7:0] w);
    int n = 0;
    data  = w;
    valid = 1'b1;
    while (!g_m[0].ready_m && n < 5000) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while (busy !== '0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    check_eq("idle_timeout", 32'(busy), 32'(0));
    repeat (5) @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    chk_en = 1'b1;
    check_eq("reset_txd",   32'(txd),   32'({NI{1'b1}}));
    check_eq("reset_ready", 32'(ready), 32'({NI{1'b1}}));
    check_eq("reset_busy",  32'(busy),  32'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    send(8'hA5);
    wait_idle(3000);
    send(8'h07);
    wait_idle(3000);
    send(8'h00);
    send(8'hFF);
    wait_idle(3000);

    for (int i = 0; i < 6; i++) send(8'hC0 + 8'(i));
    wait_idle(6000);

    send(8'h11);
    send(8'h22);
    send(8'h33);
    begin
      int n = 0;
      while (!(g_m[0].active && g_m[0].t == 4 * BL + 3) && n < 2000) begin
        @(negedge clk);
        n++;
      end
      check_eq("reach_data_bit3", 32'(g_m[0].active), 32'(1));
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("midrst_txd",   32'(txd),   32'({NI{1'b1}}));
    check_eq("midrst_ready", 32'(ready), 32'({NI{1'b1}}));
    check_eq("midrst_busy",  32'(busy),  32'(0));
    repeat (300) @(negedge clk);
    send(8'h5A);
    wait_idle(3000);

    for (int c = 0; c < 800; c++) begin
      valid = ($urandom_range(0, 2) != 0);
      data  = 8'($urandom);
      @(negedge clk);
    end
    valid = 1'b0;
    wait_idle(6000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

Buffered UART transmitter, the transmit counterpart of the team's UART receiver, sharing its parameter set and framing rules. It accepts user words over a valid/ready handshake into a small synchronous FIFO and serialises each word onto `uart_txd`. The frame is start bit, data LSB first, optional check bit, then stop bits. The block sits between user logic in the `clk` domain and the board UART pin.

## Interface
- `CLK_FRAC`, 50: `clk` frequency in units of 100 kHz.
- `BAUD`, 19200: line rate in bit/s; max 10M.
- `DATA_WIDTH`, 8: data bits per frame.
- `CHECK_BIT`, "none": one of "even", "odd", "mask", "space", "none".
- `END_WIDTH`, 1: number of stop bits.
- `FIFO_DEPTH`, 16: FIFO words; power of 2, ≥2.
- `clk` in 1: clock.
- `rst` in 1: reset `rst`, synchronous, active-high.
- `i_user_tx_data` in DATA_WIDTH: word to send.
- `i_user_tx_valid` in 1: `i_user_tx_data` is valid.
- `o_user_tx_ready` in/out: out 1; FIFO not full.
- `o_tx_busy` out 1: FSM not IDLE or FIFO non-empty.
- `uart_txd` out 1: serial line, idle high, registered.

## Operation
- Bit length `BL = CLK_FRAC*100000/BAUD` clocks, using integer division; BL ≥ 2 required.
- Stop period is `END_WIDTH*BL` clocks, one contiguous high interval.
- The baud counter is wide enough for `END_WIDTH*BL-1`.
- A word is accepted on any edge where `i_user_tx_valid & o_user_tx_ready`; data is ignored otherwise.
- `o_user_tx_ready = ~full`, registered from the FIFO count.
- When the FIFO is full, no write is accepted even if a pop occurs in the same cycle (no bypass).
- Simultaneous push and pop when not full leaves the count unchanged.
- FSM states: IDLE, START, DATA, CHECK, STOP.
  - IDLE → START when FIFO non-empty: pop the word into the shift register and compute the check bit.
  - START → DATA after BL clocks.
  - DATA shifts out DATA_WIDTH bits, BL clocks each, LSB first.
  - DATA → CHECK if `CHECK_BIT != "none"`, else DATA → STOP.
  - CHECK → STOP after BL clocks.
  - At the end of STOP: go to START with a pop if the FIFO is non-empty (no idle gap between frames), else go to IDLE.
- Check bit values:
  - even: XOR of the data bits.
  - odd: inverse of that XOR.
  - mask: 1.
  - space: 0.
- `uart_txd` level by state: START 0; DATA the current bit; CHECK the check bit; STOP and IDLE 1.
- Reset, including mid-frame:
  - FIFO is emptied and FSM goes to IDLE.
  - `uart_txd` = 1, `o_user_tx_ready` = 1, `o_tx_busy` = 0 from the first edge after `rst` asserts.
  - Any partially sent frame is abandoned.

## Timing
- Reset values: `uart_txd` = 1, `o_user_tx_ready` = 1, `o_tx_busy` = 0.
- Accept-to-line latency: a word accepted at edge k into an empty FIFO with the FSM in IDLE is popped at edge k+1. `uart_txd` goes low after edge k+1.
- `o_tx_busy` rises after edge k.
- Each line segment lasts exactly BL clocks; stop lasts exactly `END_WIDTH*BL` clocks.
- Frame length: `(1+DATA_WIDTH+(CHECK_BIT!="none")+END_WIDTH)*BL` clocks.
- Back-to-back frames: the next start bit begins the clock immediately after the last stop clock.
- `o_tx_busy` falls on the same edge the FSM enters IDLE with the FIFO empty.

## Test plan
- Single frame:
  - Setup: CLK_FRAC=50, BAUD=500000 (BL=10), CHECK_BIT="even", END_WIDTH=1.
  - Stimulus: write 0xA5.
  - Required response: `uart_txd` reads 0,1,0,1,0,0,1,0,1,0,1, each held 10 clocks (110 total). Start bit goes low 1 edge after the accept edge. `o_tx_busy` deasserts right after the stop bit.
- Parity variants:
  - Stimulus: 0x07 under each `CHECK_BIT` setting.
  - Required check bit: even → 1, odd → 0, mask → 1, space → 0.
  - With "none": frame is 100 clocks and has no check slot.
- Stop width: END_WIDTH=2, two consecutive words 0x00 then 0xFF → stop high for exactly 20 clocks, and the second start bit begins on the very next clock.
- FIFO full:
  - Setup: FIFO_DEPTH=4, BL=10.
  - Stimulus: `i_user_tx_valid` held high with 6 distinct words from edge k.
  - Required response:
    - Words 1–5 are accepted at edges k..k+4.
    - `o_user_tx_ready` is low from k+5 until the pop at the end of frame 1.
    - Word 6 is accepted on the edge after `o_user_tx_ready` returns high.
    - All 6 words are transmitted in order.
- Reset mid-frame:
  - Stimulus: assert `rst` for 1 clock during DATA bit 3 with 2 words queued.
  - Required response: `uart_txd` is 1 after that edge, `o_tx_busy` = 0, `o_user_tx_ready` = 1, and no further frames are sent.
  - A following write produces a clean frame.
- Loopback: connect `uart_txd` to the team UART receiver with matching parameters and send 256 random words → the receiver outputs identical data with `o_user_rx_err` = 0 throughout.
